// File: rtl/axi_mst_rr_arbiter.sv
// Round-robin arbiter sharing a single-beat AXI4-Lite master command port among
// N_REQ requesters. One transaction is outstanding at a time, and a watchdog flags a stalled master.
module axi_mst_rr_arbiter #(
  parameter int N_REQ          = 4,
  parameter int IDX_W          = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_write,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          req_done,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [IDX_W-1:0]          grant_idx,
  output logic                      busy,
  output logic                      err_timeout,
  input  logic                      err_clear,
  output logic                      m_start,
  output logic                      m_write,
  output logic [ADDR_W-1:0]         m_addr,
  output logic [DATA_W-1:0]         m_wdata,
  input  logic [DATA_W-1:0]         m_rdata,
  input  logic                      m_done
);

  localparam int unsigned NREQ_U = N_REQ;
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state, state_n;
  logic                m_done_q;
  logic [DATA_W-1:0]   m_rdata_q;
  logic [CNT_W-1:0]    wd_cnt, wd_cnt_n;
  logic [IDX_W-1:0]    grant_n;
  logic                m_write_n;
  logic [ADDR_W-1:0]   m_addr_n;
  logic [DATA_W-1:0]   m_wdata_n;
  logic [DATA_W-1:0]   rsp_rdata_n;
  logic [N_REQ-1:0]    req_done_n;
  logic                err_n;
  logic                wd_set;
  logic                found;
  int unsigned         cand;

  always_comb begin
    state_n     = state;
    wd_cnt_n    = wd_cnt;
    grant_n     = grant_idx;
    m_write_n   = m_write;
    m_addr_n    = m_addr;
    m_wdata_n   = m_wdata;
    rsp_rdata_n = rsp_rdata;
    req_done_n  = '0;
    wd_set      = 1'b0;
    found       = 1'b0;
    cand        = 0;
    case (state)
      IDLE: begin
        // scan upward from the last winner so it ends up with lowest priority
        for (int unsigned k = 1; k <= NREQ_U; k++) begin
          cand = 32'(grant_idx) + k;
          if (cand >= NREQ_U) cand = cand - NREQ_U;
          if (!found && req_valid[cand]) begin
            found     = 1'b1;
            grant_n   = IDX_W'(cand);
            m_write_n = req_write[cand];
            m_addr_n  = req_addr[cand*ADDR_W +: ADDR_W];
            m_wdata_n = req_wdata[cand*DATA_W +: DATA_W];
          end
        end
        if (found) state_n = ISSUE;
      end
      ISSUE: begin
        wd_cnt_n = '0;
        state_n  = WAIT;
      end
      WAIT: begin
        if (m_done_q) begin
          state_n = RESP;
          if (!m_write) rsp_rdata_n = m_rdata_q;
        end else if (wd_cnt != TMO) begin
          wd_cnt_n = wd_cnt + 1'b1;
        end
        wd_set = (TIMEOUT_CYCLES != 0) && (wd_cnt_n == TMO);
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (state_n == RESP) req_done_n[grant_n] = 1'b1;
    if (wd_set)         err_n = 1'b1;
    else if (err_clear) err_n = 1'b0;
    else                err_n = err_timeout;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state       <= IDLE;
      m_done_q    <= 1'b0;
      m_rdata_q   <= '0;
      wd_cnt      <= '0;
      grant_idx   <= IDX_W'(N_REQ - 1);
      m_write     <= 1'b0;
      m_addr      <= '0;
      m_wdata     <= '0;
      rsp_rdata   <= '0;
      req_done    <= '0;
      m_start     <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      // master completion is registered first; only completions seen while waiting count
      m_done_q    <= m_done && (state == WAIT);
      m_rdata_q   <= m_rdata;
      wd_cnt      <= wd_cnt_n;
      grant_idx   <= grant_n;
      m_write     <= m_write_n;
      m_addr      <= m_addr_n;
      m_wdata     <= m_wdata_n;
      rsp_rdata   <= rsp_rdata_n;
      req_done    <= req_done_n;
      m_start     <= (state_n == ISSUE);
      busy        <= (state_n != IDLE);
      err_timeout <= err_n;
    end
  end

endmodule

// File: tb/tb_axi_mst_rr_arbiter.sv
// Randomized bench for axi_mst_rr_arbiter against a transaction-level model of
// round-robin selection, command latching, response timing and the watchdog.
module tb_axi_mst_rr_arbiter;

  logic         ACLK = 1'b0;
  logic         ARESET;
  logic [3:0]   req_valid, req_write, req_done;
  logic [127:0] req_addr, req_wdata;
  logic [31:0]  rsp_rdata, m_addr, m_wdata, m_rdata;
  logic [1:0]   grant_idx;
  logic         busy, err_timeout, err_clear, m_start, m_write, m_done;

  axi_mst_rr_arbiter #(
    .N_REQ(4), .IDX_W(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_done(req_done),
    .rsp_rdata(rsp_rdata), .grant_idx(grant_idx), .busy(busy),
    .err_timeout(err_timeout), .err_clear(err_clear), .m_start(m_start),
    .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .m_done(m_done)
  );

  always #5 ACLK = ~ACLK;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  logic [3:0]  vmask;
  logic        c_write [4];
  logic [31:0] c_addr  [4];
  logic [31:0] c_wdata [4];
  int          exp_last;
  logic [31:0] exp_rdata;
  int          done_cnt [4];
  int          order [$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  // lowest set bit above the last winner, otherwise lowest set bit overall
  function automatic int pick(input int last, input logic [3:0] mask);
    for (int i = last + 1; i < 4; i++) if (mask[i]) return i;
    for (int i = 0; i <= last; i++) if (mask[i]) return i;
    return -1;
  endfunction

  task automatic new_cmd(input int i);
    c_write[i] = 1'($urandom);
    c_addr[i]  = $urandom;
    c_wdata[i] = $urandom;
  endtask

  task automatic apply_bus;
    for (int i = 0; i < 4; i++) begin
      req_valid[i]           = vmask[i];
      req_write[i]           = c_write[i];
      req_addr[i*32 +: 32]   = c_addr[i];
      req_wdata[i*32 +: 32]  = c_wdata[i];
    end
  endtask

  // Arbitration edge, optional spurious m_done during ISSUE, completion dly cycles after m_start.
  task automatic txn(input int dly, input logic [31:0] rd, input bit spurious,
                     input bit renew, output int w);
    tick;
    w = pick(exp_last, vmask);
    if (w < 0) begin
      check("idle_no_start", m_start, 0);
      check("idle_busy", busy, 0);
      check("idle_grant_hold", grant_idx, exp_last);
      return;
    end
    check("grant_start", m_start, 1);
    check("grant_busy", busy, 1);
    check("grant_idx", grant_idx, w);
    check("m_addr", m_addr, c_addr[w]);
    check("m_wdata", m_wdata, c_wdata[w]);
    check("m_write", m_write, c_write[w]);
    exp_last = w;
    req_addr[w*32 +: 32]  = ~c_addr[w];
    req_wdata[w*32 +: 32] = ~c_wdata[w];
    req_write[w]          = ~c_write[w];
    if (spurious) begin
      m_done  = 1'b1;
      m_rdata = $urandom;
    end
    tick;
    m_done = 1'b0;
    check("start_one_cycle", m_start, 0);
    for (int k = 1; k < dly; k++) begin
      tick;
      check("wait_no_done", req_done, 0);
      check("wait_busy", busy, 1);
    end
    m_done  = 1'b1;
    m_rdata = rd;
    tick;
    m_done  = 1'b0;
    m_rdata = $urandom;
    check("done_lat1", req_done, 0);
    tick;
    if (!c_write[w]) exp_rdata = rd;
    check("req_done", req_done, 4'b0001 << w);
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("m_addr_hold", m_addr, c_addr[w]);
    check("resp_busy", busy, 1);
    done_cnt[w]++;
    order.push_back(w);
    if (renew) new_cmd(w);
    else vmask[w] = 1'b0;
    apply_bus;
    tick;
    check("done_one_cycle", req_done, 0);
    check("idle_after_resp", busy, 0);
  endtask

  // Transaction with no master response until after the watchdog fires.
  task automatic stall_txn(input bit clr);
    int w;
    tick;
    w = pick(exp_last, vmask);
    check("wd_grant", grant_idx, w);
    exp_last = w;
    err_clear = clr;
    for (int k = 0; k < 16; k++) begin
      tick;
      check("wd_not_yet", err_timeout, 0);
    end
    tick;
    check("wd_set", err_timeout, 1);
    for (int k = 0; k < 4; k++) begin
      tick;
      check("wd_sticky", err_timeout, 1);
      check("wd_still_wait", busy, 1);
      check("wd_no_done", req_done, 0);
    end
    err_clear = 1'b0;
    m_done = 1'b1;
    m_rdata = 32'hA5A5_0F0F;
    tick;
    m_done = 1'b0;
    tick;
    if (!c_write[w]) exp_rdata = 32'hA5A5_0F0F;
    check("wd_late_done", req_done, 4'b0001 << w);
    check("wd_late_rdata", rsp_rdata, exp_rdata);
    vmask[w] = 1'b0;
    apply_bus;
    tick;
    check("wd_idle", busy, 0);
    check("wd_hold_in_idle", err_timeout, 1);
    err_clear = 1'b1;
    tick;
    err_clear = 1'b0;
    check("wd_cleared", err_timeout, 0);
  endtask

  initial begin
    int w;
    ARESET = 1'b1;
    err_clear = 1'b0;
    m_done = 1'b0;
    m_rdata = '0;
    vmask = '0;
    for (int i = 0; i < 4; i++) begin
      new_cmd(i);
      done_cnt[i] = 0;
    end
    apply_bus;
    exp_last = 3;
    exp_rdata = '0;
    tick;
    tick;
    check("rst_busy", busy, 0);
    check("rst_start", m_start, 0);
    check("rst_done", req_done, 0);
    check("rst_grant", grant_idx, 3);
    check("rst_err", err_timeout, 0);
    check("rst_addr", m_addr, 0);
    check("rst_rdata", rsp_rdata, 0);
    ARESET = 1'b0;

    // single read by requester 0
    c_write[0] = 1'b0;
    c_addr[0] = 32'h4000_0010;
    vmask = 4'b0001;
    apply_bus;
    txn(5, 32'hDEAD_BEEF, 1'b0, 1'b0, w);
    check("read_winner", w, 0);
    check("read_rdata", rsp_rdata, 32'hDEAD_BEEF);

    // single write by requester 2
    c_write[2] = 1'b1;
    c_addr[2]  = 32'h4000_0020;
    c_wdata[2] = 32'h1234_5678;
    vmask = 4'b0100;
    apply_bus;
    txn(3, 32'h0BAD_F00D, 1'b0, 1'b0, w);
    check("write_winner", w, 2);
    check("write_rdata_kept", rsp_rdata, 32'hDEAD_BEEF);

    // all four requesting continuously
    ARESET = 1'b1;
    tick;
    ARESET = 1'b0;
    exp_last = 3;
    exp_rdata = '0;
    order.delete();
    for (int i = 0; i < 4; i++) begin
      new_cmd(i);
      done_cnt[i] = 0;
    end
    vmask = 4'b1111;
    apply_bus;
    for (int t = 0; t < 8; t++) txn(1 + int'($urandom_range(3)), $urandom, 1'b0, 1'b1, w);
    for (int t = 0; t < 8; t++) check("rr_order", order[t], t % 4);
    for (int i = 0; i < 4; i++) check("rr_count", done_cnt[i], 2);
    vmask = '0;
    apply_bus;

    // rotation: after serving 1, requester 3 beats 1
    new_cmd(1);
    vmask = 4'b0010;
    apply_bus;
    txn(2, $urandom, 1'b0, 1'b0, w);
    new_cmd(1);
    new_cmd(3);
    vmask = 4'b1010;
    apply_bus;
    txn(2, $urandom, 1'b0, 1'b1, w);
    check("rot_first", w, 3);
    txn(2, $urandom, 1'b0, 1'b0, w);
    check("rot_second", w, 1);
    vmask = '0;
    apply_bus;

    // watchdog, then set-wins-over-clear
    new_cmd(2);
    vmask = 4'b0100;
    apply_bus;
    stall_txn(1'b0);
    new_cmd(0);
    vmask = 4'b0001;
    apply_bus;
    stall_txn(1'b1);

    // randomized traffic
    for (int it = 0; it < 80; it++) begin
      for (int i = 0; i < 4; i++) begin
        if (!vmask[i] && $urandom_range(9) < 4) begin
          new_cmd(i);
          vmask[i] = 1'b1;
        end else if (vmask[i] && $urandom_range(9) == 0) begin
          vmask[i] = 1'b0;
        end
      end
      apply_bus;
      txn(1 + int'($urandom_range(7)), $urandom, ($urandom_range(3) == 0),
          1'($urandom), w);
      check("rand_err_quiet", err_timeout, 0);
    end
    vmask = '0;
    apply_bus;

    // reset in the middle of WAIT
    new_cmd(1);
    vmask = 4'b0010;
    apply_bus;
    tick;
    check("mid_grant", m_start, 1);
    repeat (3) tick;
    vmask = '0;
    apply_bus;
    ARESET = 1'b1;
    tick;
    ARESET = 1'b0;
    exp_last = 3;
    exp_rdata = '0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", req_done, 0);
    check("mid_rst_grant", grant_idx, 3);
    check("mid_rst_addr", m_addr, 0);
    m_done = 1'b1;
    tick;
    m_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      check("mid_rst_no_done", req_done, 0);
      check("mid_rst_idle", busy, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
